multi_div_16by8: RTL and testbench
==================================

Name: multi_div_16by8

Overview:
- Sequential radix-2 restoring divider; the inverse datapath of the team's shift-and-add sequential multiplier.
- Takes a WIDTH_N-bit unsigned dividend and a WIDTH_D-bit unsigned divisor. Produces quotient and remainder one bit per clock.
- Sits beside the multiplier in the arithmetic unit and uses the same rdy-style completion flag, extended with a start/busy handshake.

Parameters:
- WIDTH_N, 16, dividend and quotient width.
- WIDTH_D, 8, divisor and remainder width (WIDTH_D <= WIDTH_N).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; operands are sampled on the same edge.
- dividend  input  WIDTH_N  unsigned dividend.
- divisor  input  WIDTH_D  unsigned divisor.
- quotient  output  WIDTH_N  registered result.
- remainder  output  WIDTH_D  registered result.
- busy  output  1  high while a division is in progress.
- rdy  output  1  high while quotient/remainder hold a valid result.
- div_by_zero  output  1  the last accepted request had divisor == 0.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; quotient=0, remainder=0, busy=0, rdy=0, div_by_zero=0; all internal registers cleared. Reset mid-division aborts it, and no result is produced.
- States: IDLE, CALC, DONE.
- start is accepted only in IDLE or DONE. start during CALC is ignored; the operation in flight is unaffected.
- Accept edge, divisor != 0:
  - Latch dividend into shift register q_sr and divisor into d_r.
  - Clear partial remainder r_sr (WIDTH_D+1 bits) and iteration counter ctr.
  - busy=1, rdy=0, div_by_zero=0; state -> CALC.
- Accept edge, divisor == 0:
  - state -> DONE directly.
  - quotient = all ones, remainder = dividend[WIDTH_D-1:0], div_by_zero=1, rdy=1, busy=0.
  - Result is visible after that single edge.
- CALC, each edge (one iteration):
  - t = {r_sr[WIDTH_D-1:0], q_sr[WIDTH_N-1]}.
  - If t >= d_r: r_sr = t - d_r and shift 1 into q_sr LSB.
  - Else: r_sr = t and shift 0 into q_sr LSB.
  - q_sr shifts left by one; ctr increments.
- Completion:
  - The iteration with ctr == WIDTH_N-1 is the last.
  - On that edge: quotient <= final q_sr, remainder <= final r_sr[WIDTH_D-1:0], rdy=1, busy=0, state -> DONE.
  - Latency: exactly WIDTH_N edges after the accept edge (16 by default).
- Width rule: r_sr is WIDTH_D+1 bits so the compare never overflows. Final remainder < divisor always.
- DONE:
  - Outputs and rdy hold until the next accepted start.
  - A start in DONE behaves as an accept from IDLE: rdy drops on that edge.
  - Back-to-back operations need no idle cycle.
- quotient/remainder change only on completion or reset. They are not updated during CALC.
- busy and rdy are never high simultaneously.

Test Plan:
- 1000 / 7: start for one cycle -> busy for 16 cycles; rdy rises on the 16th edge after accept; quotient=142, remainder=6, div_by_zero=0.
- Corner values:
  - 0xFFFF / 0xFF -> quotient=257, remainder=0.
  - 0xFFFF / 1 -> quotient=0xFFFF, remainder=0.
  - 5 / 10 -> quotient=0, remainder=5.
- 0x1234 / 0 -> one edge later rdy=1, div_by_zero=1, quotient=0xFFFF, remainder=0x34, busy never asserted.
- start 200/3, then pulse start with 9/2 at cycle 5 -> second request ignored; result 66 r 2 at cycle 16.
- Mid-operation reset: pull reset low at cycle 8 -> all outputs 0 immediately. After release: idle, no rdy until a new start; a new start of 100/9 -> 11 r 1.
- From DONE, start 50/5 in the same cycle rdy is observed -> rdy drops next edge; 16 edges later quotient=10, remainder=0.

Source files
------------

// File: rtl/multi_div_16by8.sv
// multi_div_16by8: sequential radix-2 restoring divider.
// Divides an unsigned WIDTH_N-bit dividend by an unsigned WIDTH_D-bit divisor,
// resolving one quotient bit per clock. A start pulse in IDLE or DONE launches
// an operation; busy is high while iterating and rdy is high while the
// quotient/remainder outputs hold a valid result. A zero divisor short-cuts
// straight to DONE with a saturated quotient and flags div_by_zero.
module multi_div_16by8 #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               busy,
  output logic               rdy,
  output logic               div_by_zero
);

  // Iteration counter width: enough to count WIDTH_N iterations (0..WIDTH_N-1).
  localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working registers: dividend shifts out of q_sr MSB-first while quotient
  // bits shift in at the LSB; r_sr carries one guard bit above the divisor
  // width so the trial value can never overflow the compare.
  logic [WIDTH_N-1:0] q_sr;
  logic [WIDTH_D:0]   r_sr;
  logic [WIDTH_D-1:0] d_r;
  logic [CW-1:0]      ctr;

  logic               accept;
  logic               zero_div;
  logic               last_iter;
  logic [WIDTH_D:0]   trial;
  logic [WIDTH_D:0]   diff;
  logic               fits;
  logic [WIDTH_D:0]   r_nxt;
  logic [WIDTH_N-1:0] q_nxt;

  // The guard bit of r_sr is always zero after a restore step, so the next
  // trial value is formed from the lower WIDTH_D bits only.
  logic               r_msb_unused;
  assign r_msb_unused = r_sr[WIDTH_D];

  // Handshake decode: a request is honoured only when no division is running.
  assign accept    = start && (state != CALC);
  assign zero_div  = (divisor == '0);
  assign last_iter = (ctr == CW'(WIDTH_N - 1));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign trial = {r_sr[WIDTH_D-1:0], q_sr[WIDTH_N-1]};
  assign fits  = (trial >= {1'b0, d_r});
  assign diff  = trial - {1'b0, d_r};
  assign r_nxt = fits ? diff : trial;
  assign q_nxt = {q_sr[WIDTH_N-2:0], fits};

  // Status flags are pure decodes of the state register, so busy and rdy
  // are mutually exclusive by construction and glitch-free.
  assign busy = (state == CALC);
  assign rdy  = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one iteration per cycle in CALC,
  // result registers loaded only on completion or on a divide-by-zero accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these are a handful of flops, not a memory array, so every one is reset to a known value.
      q_sr        <= '0;
      r_sr        <= '0;
      d_r         <= '0;
      ctr         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend[WIDTH_D-1:0];
        div_by_zero <= 1'b1;
      end else begin
        // NOTE: non-blocking assignments so every register samples pre-edge values in parallel.
        q_sr        <= dividend;
        d_r         <= divisor;
        r_sr        <= '0;
        ctr         <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (state == CALC) begin
      q_sr <= q_nxt;
      r_sr <= r_nxt;
      ctr  <= ctr + 1'b1;
      if (last_iter) begin
        quotient  <= q_nxt;
        remainder <= r_nxt[WIDTH_D-1:0];
      end
    end
  end

endmodule

// File: tb/tb_multi_div_16by8.sv
// Testbench for multi_div_16by8: directed vectors with hand-computed results.
// Stimulus pushes the expected result and completion cycle into a scoreboard;
// a monitor pops and compares on every rising edge of rdy.
module tb_multi_div_16by8;

  localparam int WN = 16;
  localparam int WD = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [WN-1:0] dividend;
  logic [WD-1:0] divisor;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remainder;
  logic          busy;
  logic          rdy;
  logic          div_by_zero;

  typedef struct {
    string         name;
    logic [WN-1:0] q;
    logic [WD-1:0] r;
    logic          dbz;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic rdy_q  = 1'b0;

  multi_div_16by8 #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .rdy         (rdy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so completion latency can be checked exactly.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one start pulse; optionally register the expected result.
  task automatic issue(input logic [WN-1:0] n, input logic [WD-1:0] d,
                       input bit expect_result, input string name,
                       input logic [WN-1:0] eq, input logic [WD-1:0] er);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    if (expect_result) begin
      e.name = name;
      e.q    = eq;
      e.r    = er;
      e.dbz  = (d == '0);
      e.cyc  = cyc + 1 + ((d == '0) ? 0 : WN);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait until the monitor has consumed every expected result, bounded.
  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: rdy not seen, %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rdy && !rdy_q) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rdy: rdy rose with q=0x%0h r=0x%0h, expected no result", quotient, remainder);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_quotient"},  32'(quotient),    32'(mon_e.q));
        check({mon_e.name, "_remainder"}, 32'(remainder),   32'(mon_e.r));
        check({mon_e.name, "_dbz"},       32'(div_by_zero), 32'(mon_e.dbz));
        check({mon_e.name, "_latency"},   32'(cyc),         32'(mon_e.cyc));
        check({mon_e.name, "_busy_low"},  32'(busy),        32'd0);
      end
    end
    rdy_q = rdy;
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    #12;
    check("reset_quotient",  32'(quotient),    32'd0);
    check("reset_remainder", 32'(remainder),   32'd0);
    check("reset_busy",      32'(busy),        32'd0);
    check("reset_rdy",       32'(rdy),         32'd0);
    check("reset_dbz",       32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Divide by zero from IDLE: result one edge after accept, busy never high.
    issue(16'h1234, 8'h00, 1'b1, "div0", 16'hFFFF, 8'h34);
    drain("div0");

    // 1000 / 7 = 142 r 6; busy while iterating.
    issue(16'd1000, 8'd7, 1'b1, "d1000_7", 16'd142, 8'd6);
    check("d1000_7_busy_mid", 32'(busy), 32'd1);
    check("d1000_7_rdy_mid",  32'(rdy),  32'd0);
    drain("d1000_7");

    // 0xFFFF / 0xFF = 257 r 0; previous result must hold while iterating.
    issue(16'hFFFF, 8'hFF, 1'b1, "dffff_ff", 16'd257, 8'd0);
    check("hold_quotient_in_calc",  32'(quotient),  32'd142);
    check("hold_remainder_in_calc", 32'(remainder), 32'd6);
    drain("dffff_ff");

    issue(16'hFFFF, 8'h01, 1'b1, "dffff_1", 16'hFFFF, 8'd0);
    drain("dffff_1");

    issue(16'd5, 8'd10, 1'b1, "d5_10", 16'd0, 8'd5);
    drain("d5_10");

    issue(16'h8000, 8'h80, 1'b1, "d8000_80", 16'd256, 8'd0);
    drain("d8000_80");

    // 43981 / 59 = 745 r 26
    issue(16'hABCD, 8'h3B, 1'b1, "dabcd_3b", 16'd745, 8'd26);
    drain("dabcd_3b");

    // 200 / 3 with a 9 / 2 request pulsed mid-calculation: must be ignored.
    issue(16'd200, 8'd3, 1'b1, "d200_3", 16'd66, 8'd2);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd9;
    divisor  = 8'd2;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", 32'(busy), 32'd1);
    drain("d200_3");

    // Back-to-back from DONE.
    check("done_rdy_before_restart", 32'(rdy), 32'd1);
    issue(16'd50, 8'd5, 1'b1, "d50_5", 16'd10, 8'd0);
    check("restart_rdy_dropped", 32'(rdy), 32'd0);
    drain("d50_5");

    // Mid-operation reset aborts the division; no result may appear.
    issue(16'd100, 8'd9, 1'b0, "", '0, '0);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_quotient",  32'(quotient),    32'd0);
    check("midreset_remainder", 32'(remainder),   32'd0);
    check("midreset_busy",      32'(busy),        32'd0);
    check("midreset_rdy",       32'(rdy),         32'd0);
    check("midreset_dbz",       32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_idle_rdy",  32'(rdy),  32'd0);
    check("post_reset_idle_busy", 32'(busy), 32'd0);

    issue(16'd100, 8'd9, 1'b1, "d100_9", 16'd11, 8'd1);
    drain("d100_9");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
